// File: rtl/evolved_circuit_prober_pkg.sv
// Shared types for the evolved-circuit prober: FSM state encoding, the
// captured per-vector result record and a saturating increment.
// Result fields are sized to the largest supported configuration.
// The top slices them down to its own parameters.
// The high-time field exists only when PROBER_HIGH_TIME_EN is defined.
`timescale 1ns/1ps
package prober_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, REPORT} state_t;

  localparam int VEC_MAX = 16;
  localparam int CNT_MAX = 32;

  typedef struct packed {
    logic [VEC_MAX-1:0] vector;
    logic [CNT_MAX-1:0] edges;
    logic               level;
    logic               osc;
`ifdef PROBER_HIGH_TIME_EN
    logic [CNT_MAX-1:0] high;
`endif
  } result_t;

  function automatic logic [CNT_MAX-1:0] sat_inc(input logic [CNT_MAX-1:0] value,
                                                 input logic [CNT_MAX-1:0] limit);
    return (value >= limit) ? value : value + CNT_MAX'(1);
  endfunction

endpackage

// File: rtl/evolved_circuit_prober_if.sv
// Result channel between the prober and the host-side consumer.
// The channel is a valid/ready handshake.
// res_high is present only when PROBER_HIGH_TIME_EN is defined.
`timescale 1ns/1ps
interface evolved_circuit_prober_if #(
  parameter int IN_WIDTH  = 2,
  parameter int CNT_WIDTH = 16
);
  logic                 res_valid;
  logic                 res_ready;
  logic [IN_WIDTH-1:0]  res_vector;
  logic [CNT_WIDTH-1:0] res_edges;
  logic                 res_level;
  logic                 res_osc;
`ifdef PROBER_HIGH_TIME_EN
  logic [CNT_WIDTH-1:0] res_high;

  modport master (output res_valid, res_vector, res_edges, res_level, res_osc, res_high,
                  input  res_ready);
  modport slave  (input  res_valid, res_vector, res_edges, res_level, res_osc, res_high,
                  output res_ready);
`else
  modport master (output res_valid, res_vector, res_edges, res_level, res_osc,
                  input  res_ready);
  modport slave  (input  res_valid, res_vector, res_edges, res_level, res_osc,
                  output res_ready);
`endif
endinterface

// File: rtl/evolved_circuit_prober_sync_edge_det.sv
// Two-flop synchronizer for the asynchronous circuit output, plus a
// rising-edge detector on the synchronized level.
`timescale 1ns/1ps
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);
  logic meta;
  logic prev;

  // Synchronize the input and remember the previous synchronized level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b0;
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      meta  <= async_in;
      level <= meta;
      prev  <= level;
    end
  end

  assign rise = level & ~prev;
endmodule

// File: rtl/evolved_circuit_prober.sv
// Sweeps every input vector onto an evolved circuit.
// Each vector is held for SETTLE_CYCLES and then the synchronized output is
// sampled for WINDOW_CYCLES. Edge count, final level and an oscillation flag
// are then reported over a valid/ready channel.
// Define PROBER_HIGH_TIME_EN to also report window cycles spent high.
`timescale 1ns/1ps
module evolved_circuit_prober
  import prober_pkg::*;
#(
  parameter int IN_WIDTH      = 2,
  parameter int SETTLE_CYCLES = 256,
  parameter int WINDOW_CYCLES = 4096,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [IN_WIDTH-1:0]      dut_in,
  input  logic                     dut_out,
  evolved_circuit_prober_if.master res
);

  if (SETTLE_CYCLES < 2) begin : g_chk_settle
    $error("evolved_circuit_prober: SETTLE_CYCLES must be at least 2");
  end
  if (WINDOW_CYCLES < 1) begin : g_chk_window
    $error("evolved_circuit_prober: WINDOW_CYCLES must be at least 1");
  end
  if (IN_WIDTH >= VEC_MAX || CNT_WIDTH >= CNT_MAX) begin : g_chk_width
    $error("evolved_circuit_prober: IN_WIDTH or CNT_WIDTH too large for result_t");
  end

  localparam int CYC_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX);
  localparam logic [CYC_W-1:0]   SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0]   WINDOW_LAST = CYC_W'(WINDOW_CYCLES - 1);
  localparam logic [IN_WIDTH:0]  VEC_LAST    = {1'b0, {IN_WIDTH{1'b1}}};
  localparam logic [CNT_MAX-1:0] SAT_LIMIT   = CNT_MAX'((64'd1 << CNT_WIDTH) - 64'd1);

  state_t               state;
  logic [IN_WIDTH:0]    vector;
  logic [CYC_W-1:0]     cyc_cnt;
  logic [CNT_MAX-1:0]   edge_cnt;
  logic [CNT_MAX-1:0]   edge_next;
  logic                 res_valid;
  result_t              result;
  logic                 sync_level;
  logic                 sync_rise;
`ifdef PROBER_HIGH_TIME_EN
  logic [CNT_MAX-1:0]   high_cnt;
  logic [CNT_MAX-1:0]   high_next;
`endif

  sync_edge_det u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (dut_out),
    .level    (sync_level),
    .rise     (sync_rise)
  );

  // Counter values including the current cycle, so the last window sample is captured
  always_comb begin
    edge_next = edge_cnt;
    if (sync_rise) edge_next = sat_inc(edge_cnt, SAT_LIMIT);
`ifdef PROBER_HIGH_TIME_EN
    high_next = high_cnt;
    if (sync_level) high_next = sat_inc(high_cnt, SAT_LIMIT);
`endif
  end

  // Sweep sequencer: settle, measure, then hold the result until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vector    <= '0;
      cyc_cnt   <= '0;
      edge_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      result    <= '0;
`ifdef PROBER_HIGH_TIME_EN
      high_cnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SETTLE;
            vector   <= '0;
            cyc_cnt  <= '0;
            edge_cnt <= '0;
            busy     <= 1'b1;
`ifdef PROBER_HIGH_TIME_EN
            high_cnt <= '0;
`endif
          end
        end
        SETTLE: begin
          edge_cnt <= '0;
`ifdef PROBER_HIGH_TIME_EN
          high_cnt <= '0;
`endif
          if (cyc_cnt == SETTLE_LAST) begin
            state   <= MEASURE;
            cyc_cnt <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        MEASURE: begin
          edge_cnt <= edge_next;
`ifdef PROBER_HIGH_TIME_EN
          high_cnt <= high_next;
`endif
          if (cyc_cnt == WINDOW_LAST) begin
            state         <= REPORT;
            cyc_cnt       <= '0;
            res_valid     <= 1'b1;
            result.vector <= VEC_MAX'(vector[IN_WIDTH-1:0]);
            result.edges  <= edge_next;
            result.level  <= sync_level;
            result.osc    <= (edge_next != '0);
`ifdef PROBER_HIGH_TIME_EN
            result.high   <= high_next;
`endif
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        REPORT: begin
          if (res.res_ready) begin
            res_valid <= 1'b0;
            if (vector == VEC_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= SETTLE;
              vector   <= vector + (IN_WIDTH+1)'(1);
              cyc_cnt  <= '0;
              edge_cnt <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dut_in         = vector[IN_WIDTH-1:0];
  assign res.res_valid  = res_valid;
  assign res.res_vector = result.vector[IN_WIDTH-1:0];
  assign res.res_edges  = result.edges[CNT_WIDTH-1:0];
  assign res.res_level  = result.level;
  assign res.res_osc    = result.osc;

`ifdef PROBER_HIGH_TIME_EN
  assign res.res_high   = result.high[CNT_WIDTH-1:0];

  logic unused_result;
  assign unused_result = ^{result.vector[VEC_MAX-1:IN_WIDTH],
                           result.edges[CNT_MAX-1:CNT_WIDTH],
                           result.high[CNT_MAX-1:CNT_WIDTH]};
`else
  logic unused_result;
  assign unused_result = ^{result.vector[VEC_MAX-1:IN_WIDTH],
                           result.edges[CNT_MAX-1:CNT_WIDTH]};
`endif

endmodule

// File: doc/evolved_circuit_prober.md
# evolved_circuit_prober

Stimulus-and-measurement harness for the evolved asynchronous LCELL circuits under test. It drives every input combination onto a circuit's input bus, waits for the circuit to settle, then samples its free-running output for a fixed window. Per vector, it reports edge count, final level and an oscillation flag to a host-side consumer over a valid/ready handshake. It sits between the test controller and one evolved-circuit instance, on the circuit's input and output ports.

## Interface
- `IN_WIDTH`, 2 — width of the circuit-under-test input bus; vectors swept 0 .. 2^IN_WIDTH-1.
- `SETTLE_CYCLES`, 256 — clk cycles each vector is held before measurement (≥ 2, elaboration-time check).
- `WINDOW_CYCLES`, 4096 — clk cycles of output sampling per vector (≥ 1).
- `CNT_WIDTH`, 16 — width of the edge and high-time counters.
- `clk` in 1 — single clock.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `start` in 1 — begin a sweep; sampled only in IDLE.
- `busy` out 1 — high from the cycle after accepted `start` until return to IDLE.
- `done` out 1 — one-cycle pulse when the sweep completes.
- `dut_in` out IN_WIDTH — stimulus to the circuit under test.
- `dut_out` in 1 — circuit output; asynchronous, may oscillate.
- `res_valid` out 1 — result available.
- `res_ready` in 1 — consumer accepts result.
- `res_vector` out IN_WIDTH — vector the result belongs to.
- `res_edges` out CNT_WIDTH — rising edges seen in window, saturating.
- `res_level` out 1 — synchronized output level on the last window cycle.
- `res_osc` out 1 — `res_edges != 0`.
- `res_high` out CNT_WIDTH — window cycles with output high, saturating; present only with the macro in Configuration.

## Operation
- Reset values:
  - state IDLE
  - `busy`=0, `done`=0, `dut_in`=0, `res_valid`=0
  - all `res_*` = 0
  - counters and synchronizer = 0
- `dut_out` passes through a 2-flop synchronizer. A rising edge is counted when the previous synchronized value is 0 and the current one is 1.
- FSM states:
  - **IDLE**
    - `start`=1 → SETTLE, vector=0, `dut_in`=0.
    - `start` in any other state is ignored.
  - **SETTLE**
    - hold `dut_in`=vector for SETTLE_CYCLES cycles, then → MEASURE.
    - counters are cleared on entry.
  - **MEASURE**
    - sample for exactly WINDOW_CYCLES cycles, then → REPORT.
    - edge and high counters saturate at 2^CNT_WIDTH-1; no wrap.
  - **REPORT**
    - `res_valid`=1; all `res_*` stable while `res_valid && !res_ready`.
    - `dut_in` is held at the current vector.
    - On the handshake cycle (`res_valid && res_ready`):
      - vector = max → IDLE, `done` pulses the next cycle.
      - otherwise vector+1 → SETTLE.
- `res_valid` drops the cycle after the handshake. `res_*` retain their last values until the next REPORT.
- Vector counter is IN_WIDTH+1 bits internally so the last-vector compare cannot wrap.
- `rst_n` asserted mid-sweep: everything returns to reset values immediately; no partial result is emitted.

## Timing
- `start` accepted at edge N → `busy`=1 and `dut_in`=0 at N+1.
- First sample counted at N+1+SETTLE_CYCLES.
- `res_valid` rises at N+1+SETTLE_CYCLES+WINDOW_CYCLES.
- Latency per vector with `res_ready` tied high: SETTLE_CYCLES+WINDOW_CYCLES+1 cycles.
- Full sweep latency: 2^IN_WIDTH × that value.
- `dut_in` changes only on SETTLE entry. The synchronizer delay of 2 cycles is absorbed by SETTLE.
- `done` and `busy` falling occur in the same cycle.

## Configuration
- `PROBER_HIGH_TIME_EN` defined:
  - `res_high` port exists.
  - a saturating counter increments on every MEASURE cycle with synchronized output = 1.
- Undefined:
  - `res_high` port, counter and associated logic are absent.
  - all other behaviour is identical.

## Structure
- Package `prober_pkg` holds:
  - state enum (IDLE, SETTLE, MEASURE, REPORT)
  - packed result struct (vector, edges, level, osc, optional high)
  - saturating-increment function
- Sub-module `sync_edge_det`: 2-flop synchronizer plus rising-edge detector, async active-low reset. Outputs `level` and `rise`.

## Test plan
Bench parameters: SETTLE=4, WINDOW=16, CNT_WIDTH=8.
1. Loopback model `dut_out = dut_in[0]`, `res_ready`=1 → 4 results, vectors 0..3, edges 0, level {0,1,0,1}, osc 0; `done` at cycle 1+4×21.
2. Model toggling `dut_out` every 2 clk cycles when `dut_in`=2'b01, else 0 → vector 1 edges=4, osc=1; `res_high`=8 with macro.
3. CNT_WIDTH=3, toggle every cycle → edges saturates at 7, no wrap.
4. `res_ready` low for 10 cycles at vector 2 → `res_*` stable for those 10 cycles; `dut_in` stays 2'b10; sweep resumes after the handshake.
5. `rst_n` low during MEASURE of vector 1 → `busy`, `res_valid`, `dut_in` = 0 immediately; no result; new `start` restarts at vector 0.
6. `start` pulsed while `busy` → ignored; exactly 4 results and one `done`.
